// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state enum
//   - byte-lane select type and classification helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANE_W = 2;
    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RMW_READ,
        S_RMW_WRITE,
        S_RESP
    } lsu_state_e;

    // Unsigned widths are legal for loads only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input lane_t lane);
        case (f3)
            F3_H, F3_HU: misaligned = lane[0];
            F3_W:        misaligned = (lane != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response channel between the execute stage and the LSU.
//   master : execute stage (drives req_*, rsp_ready)
//   slave  : load_store_unit (drives req_ready, rsp_*)
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane datapath.
//   funct3     in   width code of the latched request
//   lane       in   addr[1:0] of the latched request
//   word       in   memory word (load source or RMW merge source)
//   wdata      in   right-aligned store data (low half is all a sub-word store needs)
//   load_data  out  extracted and sign/zero-extended load value
//   merge_word out  word with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  lane_t       lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] rep;

    assign shamt   = {lane, 3'b000};
    assign shifted = word >> shamt;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            F3_W:    load_data = shifted;   // lane is 0 for a legal word access
            default: load_data = '0;
        endcase
    end

    // Store merge: replicate the store data across the word and let a lane
    // mask choose which bytes replace the captured word.
    always_comb begin
        mask = '0;
        rep  = '0;
        case (funct3)
            F3_B: begin
                mask = 32'h0000_00FF << shamt;
                rep  = {4{wdata[7:0]}};
            end
            F3_H: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                rep  = {2{wdata}};
            end
            default: begin
                mask = '0;
                rep  = '0;
            end
        endcase
    end

    assign merge_word = (word & ~mask) | (rep & mask);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle initiator for the word-organised data memory.
//   clk, rst_n   clock, asynchronous active-low reset
//   core         lsu_if.slave request/response channel from the execute stage
//   mem_read     memory read strobe
//   mem_write    memory write strobe (sampled by the memory on clk rising edge)
//   mem_addr     word-aligned byte address {addr[31:2], 2'b00}
//   mem_wdata    full word to write
//   mem_rdata    combinational read data, valid while mem_read is high
// Sub-word stores become read-modify-write; misaligned, out-of-range and
// illegal-width requests go straight to an error response without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        core,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    lsu_state_e  state_q, state_d;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] merge_word;

    assign accept  = (state_q == S_IDLE) && core.req_valid;

    // Classification is done on the live request in the accept cycle so the
    // error path can reach RESP one cycle later.
    assign req_err = !f3_legal(core.req_we, core.req_funct3)
                   || misaligned(core.req_funct3, core.req_addr[1:0])
                   || ({2'b00, core.req_addr[31:2]} >= MEM_WORDS_U);

    // Only one of the two uses is live in any state: LOAD extracts from the
    // memory bus, RMW_WRITE merges into the captured word.
    assign align_word = (state_q == S_LOAD) ? mem_rdata : merge_q;

    lsu_align u_align (
        .funct3     (f3_q),
        .lane       (addr_q[1:0]),
        .word       (align_word),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (core.req_valid) begin
                    if (req_err)                   state_d = S_RESP;
                    else if (!core.req_we)         state_d = S_LOAD;
                    else if (core.req_funct3 == F3_W) state_d = S_WRITE;
                    else                           state_d = S_RMW_READ;
                end
            end
            S_LOAD: begin
                mem_read = 1'b1;
                state_d  = S_RESP;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_d   = S_RESP;
            end
            S_RMW_READ: begin
                mem_read = 1'b1;
                state_d  = S_RMW_WRITE;
            end
            S_RMW_WRITE: begin
                mem_write = 1'b1;
                mem_wdata = merge_word;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (core.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= core.req_we;
                f3_q    <= core.req_funct3;
                addr_q  <= core.req_addr;
                wdata_q <= core.req_wdata;
                rdata_q <= '0;   // stores and errors respond with zero data
                err_q   <= req_err;
            end
            if (state_q == S_LOAD)     rdata_q <= load_data;
            if (state_q == S_RMW_READ) merge_q <= mem_rdata;
        end
    end

    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign core.req_ready = (state_q == S_IDLE);
    assign core.rsp_valid = (state_q == S_RESP);
    assign core.rsp_rdata = rdata_q;
    assign core.rsp_err   = err_q;

    // we_q documents the latched direction; the state already encodes it.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a
// 256-word behavioural memory behind the memory port.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core      (bus),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory and strobe monitor.
    logic [31:0] mem [256];
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[4]   = 32'h8899_AABB;
        mem[5]   = 32'h0000_0000;
        mem[6]   = 32'h8899_AABB;
        mem[255] = 32'hCAFE_F00D;
    end

    always @(posedge clk) begin
        if (mem_read)  begin rd_cnt <= rd_cnt + 1; last_rd_addr <= mem_addr; end
        if (mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int rd0, wr0;

    // Present a request at a negedge, let the next posedge accept it, then
    // scramble the request lines to show later changes are ignored.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h5555_5555;
    endtask

    // Cycles from the accept edge until rsp_valid is seen (1 = right after it).
    task automatic wait_rsp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    // Full transaction: issue, check latency/data/err and strobe counts, take.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_rd, input int exp_wr);
        int lat;
        check({tag, " req_ready before"}, 32'(bus.req_ready), 32'd1);
        issue(we, f3, addr, wdata);
        wait_rsp(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        take();
        check({tag, " rsp_valid after take"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state
        #12;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst mem_read", 32'(mem_read), 32'd0);
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Loads
        xact("LW 0x10", 1'b0, F3_W, 32'h10, 32'h0, 2, 32'h8899_AABB, 1'b0, 1, 0);
        check("LW 0x10 mem_addr", last_rd_addr, 32'h10);
        xact("LB 0x13", 1'b0, F3_B, 32'h13, 32'h0, 2, 32'hFFFF_FF88, 1'b0, 1, 0);
        xact("LBU 0x13", 1'b0, F3_BU, 32'h13, 32'h0, 2, 32'h0000_0088, 1'b0, 1, 0);
        xact("LH 0x12", 1'b0, F3_H, 32'h12, 32'h0, 2, 32'hFFFF_8899, 1'b0, 1, 0);
        xact("LHU 0x10", 1'b0, F3_HU, 32'h10, 32'h0, 2, 32'h0000_AABB, 1'b0, 1, 0);
        xact("LB 0x10", 1'b0, F3_B, 32'h10, 32'h0, 2, 32'hFFFF_FFBB, 1'b0, 1, 0);
        xact("LW last word", 1'b0, F3_W, 32'h3FC, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1, 0);

        // Stores
        xact("SB 0x11", 1'b1, F3_B, 32'h11, 32'h0000_00CC, 3, 32'h0, 1'b0, 1, 1);
        check("SB 0x11 mem word", mem[4], 32'h8899_CCBB);
        check("SB 0x11 wr addr", last_wr_addr, 32'h10);
        xact("SH 0x1A", 1'b1, F3_H, 32'h1A, 32'h0000_1234, 3, 32'h0, 1'b0, 1, 1);
        check("SH 0x1A mem word", mem[6], 32'h1234_AABB);
        xact("SW 0x14", 1'b1, F3_W, 32'h14, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
        check("SW 0x14 mem word", mem[5], 32'hDEAD_BEEF);

        // Errors: no strobes, response one cycle after accept
        xact("LH 0x11 misaligned", 1'b0, F3_H, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        xact("SW 0x02 misaligned", 1'b1, F3_W, 32'h02, 32'h1, 1, 32'h0, 1'b1, 0, 0);
        xact("SB f3=100 illegal", 1'b1, F3_BU, 32'h10, 32'h1, 1, 32'h0, 1'b1, 0, 0);
        xact("LW 0x400 range", 1'b0, F3_W, 32'h400, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        check("SB f3=100 mem untouched", mem[4], 32'h8899_CCBB);

        // Back-pressure on the response
        issue(1'b0, F3_W, 32'h10, 32'h0);
        wait_rsp(lat);
        check("stall latency", 32'(lat), 32'd2);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall rsp_rdata", bus.rsp_rdata, 32'h8899_CCBB);
            check("stall req_ready", 32'(bus.req_ready), 32'd0);
        end
        check("stall reads", 32'(rd_cnt - rd0), 32'd0);
        check("stall writes", 32'(wr_cnt - wr0), 32'd0);
        take();
        xact("LBU after take", 1'b0, F3_BU, 32'h10, 32'h0, 2, 32'h0000_00BB, 1'b0, 1, 0);

        // Reset in the middle of an SB read-modify-write
        issue(1'b1, F3_B, 32'h18, 32'h0000_0077);
        check("rst-mid in RMW_READ", 32'(mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst-mid mem_read", 32'(mem_read), 32'd0);
        check("rst-mid mem_write", 32'(mem_write), 32'd0);
        check("rst-mid req_ready", 32'(bus.req_ready), 32'd1);
        check("rst-mid rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst-mid writes", 32'(wr_cnt - wr0), 32'd0);
        check("rst-mid mem word", mem[6], 32'h1234_AABB);
        rst_n = 1'b1;
        @(negedge clk);
        xact("LW after reset", 1'b0, F3_W, 32'h18, 32'h0, 2, 32'h1234_AABB, 1'b0, 1, 0);

        check("no simultaneous strobes", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle initiator that drives the word-organised data memory on behalf of the core's execute stage. Accepts one RISC-V load/store request at a time over a valid/ready handshake and issues word reads and writes on the memory port. Sub-word stores become a read-modify-write; loads are byte-lane extracted and sign/zero-extended. Misaligned and out-of-range accesses are rejected without touching memory.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words behind the memory port; word index ≥ MEM_WORDS is out of range.
- `clk`  in  1  single clock; memory samples writes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present; held until taken.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, out-of-range, or illegal funct3.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  32  word-aligned byte address, {addr[31:2], 2'b00}.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  combinational read data, valid while mem_read is high.

## Operation
- States: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr, wdata; classify.
  - Error (H with addr[0]=1, W with addr[1:0]≠0, funct3 illegal for direction, addr[31:2] ≥ MEM_WORDS): → RESP with err=1, no memory strobe ever asserted.
  - Load → LOAD. SW → WRITE. SB/SH → RMW_READ.
- LOAD: mem_read=1; capture mem_rdata, extract lane by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU/W) into rsp_rdata register; → RESP.
- WRITE: mem_write=1, mem_wdata=latched wdata; → RESP.
- RMW_READ: mem_read=1; capture mem_rdata into merge register; → RMW_WRITE.
- RMW_WRITE: mem_write=1; mem_wdata = captured word with byte lane addr[1:0] (SB) or half lane addr[1] (SH) replaced by wdata[7:0]/wdata[15:0]; → RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_err stable; on rsp_ready → IDLE.
- mem_read, mem_write, mem_addr, mem_wdata decode from state and latched registers only; never from req_* inputs. mem_read and mem_write never high together.

## Timing
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, all latches 0.
- Accept at edge N (cycle in IDLE with req_valid). Earliest rsp_valid: error N+1; load/SW N+2; SB/SH N+3.
- req_ready low from edge N until the cycle after the response is taken; minimum request-to-request spacing: error 2, load/SW 3, SB/SH 4 cycles.
- rsp_ready low in RESP: stay, outputs held, no memory activity.
- Reset asserted mid-operation: strobes drop asynchronously; a write whose edge has not yet occurred is not performed; pending response discarded.
- req_* changes after acceptance have no effect.

## Structure
- `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, lane-select helper widths.
- Sub-module `lsu_align` (combinational): load extract/extend and store lane merge, instantiated once; FSM and registers stay in load_store_unit.

## Test plan
- LW addr 0x10, memory word 4 = 0x8899AABB -> one mem_read cycle at mem_addr 0x10, rsp_rdata=0x8899AABB at N+2, rsp_err=0.
- LB addr 0x13 and LBU addr 0x13 on same word -> rsp_rdata 0xFFFFFF88 and 0x00000088.
- SB addr 0x11 wdata 0x000000CC on 0x8899AABB -> read then write 0x8899CCBB, rsp_valid at N+3; SH addr 0x12 wdata 0x1234 -> 0x1234AABB.
- LH addr 0x11, SW addr 0x02, SB with funct3 100, LW addr 0x400 (MEM_WORDS=256) -> rsp_err=1 at N+1, mem_read/mem_write never asserted.
- rsp_ready held low 5 cycles after LW -> rsp_valid and rsp_rdata stable, req_ready=0, no strobes; new request accepted the cycle after take.
- rst_n pulsed low during RMW_READ of SB -> state IDLE, strobes 0, memory word unchanged.
